mmu_walker: RTL

Parametrised two-level page-table walker with separately sized, direct-mapped directory and entry caches. It translates a 32-bit virtual address to a physical address and reports page faults. Permission checks can be compiled in. It sits between the CPU lookup port and the shared memory bus, which it reads only. It replaces the fixed 64-entry translator and adds full walks, fill, flush and fault reporting.

---
 rtl/mmu_walker.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mmu_walker.sv
// Two-level page-table walker with direct-mapped directory and entry caches.
// Define MMU_WRITE_PROT_EN to fault stores to pages whose PTE bit1 is clear.
module mmu_walker #(
    parameter int unsigned DIR_ENTRIES = 64,
    parameter int unsigned ENT_ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mmu_base_i,
    input  logic        mmu_we,
    output logic [31:0] mmu_base_o,
    input  logic        flush,
    input  logic [31:0] v_addr_i,
    input  logic        v_lookup,
    input  logic        v_write,
    output logic [31:0] v_ent_o,
    output logic        v_ack_o,
    output logic        busy_o,
    output logic [31:0] addr_o,
    input  logic [31:0] data_i,
    output logic        rd_o,
    input  logic        ack_i,
    output logic        page_fault,
    output logic [31:0] page_fault_addr
);

    localparam int unsigned DirIdxW = $clog2(DIR_ENTRIES);
    localparam int unsigned EntIdxW = $clog2(ENT_ENTRIES);

    typedef enum logic [2:0] {StIdle, StQuery, StLoadDir, StLoadEnt, StDone} state_e;

    state_e      state_q, state_d;
    logic [19:0] base_q, base_d;
    logic [31:0] v_addr_q, v_addr_d;
    logic        v_write_q, v_write_d;
    logic        stale_q, stale_d;
    logic [19:0] pde_q, pde_d;
    logic [19:0] frame_q, frame_d;
    logic        fault_q, fault_d;
    logic        rd_q, rd_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] v_ent_q, v_ent_d;
    logic        v_ack_q, v_ack_d;
    logic        pf_q, pf_d;
    logic [31:0] pf_addr_q, pf_addr_d;

    // Full VPN bits are kept as tags so that a 1024-entry directory needs no zero-width tag.
    logic [DIR_ENTRIES-1:0] dir_valid_q;
    logic [9:0]             dir_tag_q   [DIR_ENTRIES];
    logic [19:0]            dir_frame_q [DIR_ENTRIES];
    logic [ENT_ENTRIES-1:0] ent_valid_q;
    logic [19:0]            ent_tag_q   [ENT_ENTRIES];
    logic [19:0]            ent_frame_q [ENT_ENTRIES];
    logic                   ent_wr_q    [ENT_ENTRIES];

    logic [DirIdxW-1:0] dir_idx;
    logic [EntIdxW-1:0] ent_idx;
    logic               dir_hit, ent_hit, ent_wr_rd;
    logic               inval, dir_fill, ent_fill;
    logic               hit_wfault, pte_wfault, pte_fault;
    logic               unused_bits;

    assign inval     = mmu_we | flush;
    assign dir_idx   = v_addr_q[22 +: DirIdxW];
    assign ent_idx   = v_addr_q[12 +: EntIdxW];
    assign dir_hit   = dir_valid_q[dir_idx] && (dir_tag_q[dir_idx] == v_addr_q[31:22]);
    assign ent_hit   = ent_valid_q[ent_idx] && (ent_tag_q[ent_idx] == v_addr_q[31:12]);
    assign ent_wr_rd = ent_wr_q[ent_idx];

`ifdef MMU_WRITE_PROT_EN
    assign hit_wfault  = v_write_q && !ent_wr_rd;
    assign pte_wfault  = v_write_q && !data_i[1];
    assign unused_bits = ^{mmu_base_i[11:0], data_i[11:2]};
`else
    assign hit_wfault  = 1'b0;
    assign pte_wfault  = 1'b0;
    assign unused_bits = ^{mmu_base_i[11:0], data_i[11:1], v_write_q, ent_wr_rd};
`endif

    assign pte_fault = !data_i[0] || pte_wfault;

    always_comb begin
        state_d   = state_q;
        base_d    = mmu_we ? mmu_base_i[31:12] : base_q;
        v_addr_d  = v_addr_q;
        v_write_d = v_write_q;
        stale_d   = stale_q;
        pde_d     = pde_q;
        frame_d   = frame_q;
        fault_d   = fault_q;
        rd_d      = rd_q;
        addr_d    = addr_q;
        v_ent_d   = v_ent_q;
        v_ack_d   = 1'b0;
        pf_d      = 1'b0;
        pf_addr_d = pf_addr_q;
        dir_fill  = 1'b0;
        ent_fill  = 1'b0;

        unique case (state_q)
            StIdle: begin
                stale_d = 1'b0;
                // The requester still holds v_lookup during the ack cycle; don't re-accept it.
                if (v_lookup && !v_ack_q) begin
                    state_d   = StQuery;
                    v_addr_d  = v_addr_i;
                    v_write_d = v_write;
                    fault_d   = 1'b0;
                end
            end
            StQuery: begin
                if (!dir_hit) begin
                    state_d = StLoadDir;
                    rd_d    = 1'b1;
                    addr_d  = {base_q, v_addr_q[31:22], 2'b00};
                end else if (!ent_hit) begin
                    state_d = StLoadEnt;
                    pde_d   = dir_frame_q[dir_idx];
                    rd_d    = 1'b1;
                    addr_d  = {dir_frame_q[dir_idx], v_addr_q[21:12], 2'b00};
                end else begin
                    state_d = StDone;
                    frame_d = ent_frame_q[ent_idx];
                    fault_d = hit_wfault;
                end
            end
            StLoadDir: begin
                if (rd_q && ack_i) begin
                    rd_d = 1'b0;
                    if (!data_i[0]) begin
                        fault_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        pde_d    = data_i[31:12];
                        dir_fill = !stale_q;
                        state_d  = StLoadEnt;
                    end
                end
            end
            StLoadEnt: begin
                // After a directory load rd_o is low for one cycle before the entry read.
                if (!rd_q) begin
                    rd_d   = 1'b1;
                    addr_d = {pde_q, v_addr_q[21:12], 2'b00};
                end else if (ack_i) begin
                    rd_d     = 1'b0;
                    frame_d  = data_i[31:12];
                    fault_d  = pte_fault;
                    ent_fill = !stale_q && !pte_fault;
                    state_d  = StDone;
                end
            end
            StDone: begin
                v_ack_d = 1'b1;
                pf_d    = fault_q;
                v_ent_d = fault_q ? 32'h0 : {frame_q, v_addr_q[11:0]};
                if (fault_q) begin
                    pf_addr_d = v_addr_q;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (inval && state_q != StIdle) begin
            stale_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            base_q    <= '0;
            v_addr_q  <= '0;
            v_write_q <= 1'b0;
            stale_q   <= 1'b0;
            pde_q     <= '0;
            frame_q   <= '0;
            fault_q   <= 1'b0;
            rd_q      <= 1'b0;
            addr_q    <= '0;
            v_ent_q   <= '0;
            v_ack_q   <= 1'b0;
            pf_q      <= 1'b0;
            pf_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            v_addr_q  <= v_addr_d;
            v_write_q <= v_write_d;
            stale_q   <= stale_d;
            pde_q     <= pde_d;
            frame_q   <= frame_d;
            fault_q   <= fault_d;
            rd_q      <= rd_d;
            addr_q    <= addr_d;
            v_ent_q   <= v_ent_d;
            v_ack_q   <= v_ack_d;
            pf_q      <= pf_d;
            pf_addr_q <= pf_addr_d;
        end
    end

    // Invalidation beats a fill landing on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_valid_q <= '0;
            ent_valid_q <= '0;
        end else if (inval) begin
            dir_valid_q <= '0;
            ent_valid_q <= '0;
        end else begin
            if (dir_fill) begin
                dir_valid_q[dir_idx] <= 1'b1;
            end
            if (ent_fill) begin
                ent_valid_q[ent_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (dir_fill && !inval) begin
            dir_tag_q[dir_idx]   <= v_addr_q[31:22];
            dir_frame_q[dir_idx] <= data_i[31:12];
        end
        if (ent_fill && !inval) begin
            ent_tag_q[ent_idx]   <= v_addr_q[31:12];
            ent_frame_q[ent_idx] <= data_i[31:12];
            ent_wr_q[ent_idx]    <= data_i[1];
        end
    end

    assign mmu_base_o      = {base_q, 12'h000};
    assign v_ent_o         = v_ent_q;
    assign v_ack_o         = v_ack_q;
    assign busy_o          = (state_q != StIdle);
    assign addr_o          = addr_q;
    assign rd_o            = rd_q;
    assign page_fault      = pf_q;
    assign page_fault_addr = pf_addr_q;

endmodule
